// File: rtl/eth_phy_10g_pkg.sv
// Shared 10GBASE-R receive definitions: sync header codes, the header validity check
// and the block-lock FSM state encoding.
package eth_phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [1:0] StHunt   = 2'd0;
  localparam logic [1:0] StSlip   = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StLocked = 2'd3;

  function automatic logic is_valid_hdr(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_hdr_err_mon.sv
// Error monitor used while block lock is held: counts sampled headers per window and the
// invalid ones among them. The caller decides when the counters clear.
module eth_phy_10g_hdr_err_mon
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned WINDOW  = 64,
  parameter int unsigned BAD_MAX = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             sample,
  input  logic                             bad,
  output logic [$clog2(BAD_MAX+1)-1:0]     bad_hdr_cnt,
  output logic                             win_done,
  output logic                             too_many_bad
);

  localparam int unsigned WinW = $clog2(WINDOW + 1);
  localparam int unsigned BadW = $clog2(BAD_MAX + 1);

  logic [WinW-1:0] win_q, win_d;
  logic [BadW-1:0] bad_q, bad_d;

  // Both flags describe the header being sampled this cycle, so the caller can act on it
  // in the same cycle the threshold is reached.
  assign win_done     = sample && (win_q == WinW'(WINDOW - 1));
  assign too_many_bad = sample && bad && (bad_q == BadW'(BAD_MAX - 1));
  assign bad_hdr_cnt  = bad_q;

  always_comb begin
    win_d = win_q;
    bad_d = bad_q;
    if (clear) begin
      win_d = '0;
      bad_d = '0;
    end else if (sample) begin
      win_d = win_q + 1'b1;
      if (bad) begin
        bad_d = bad_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q <= '0;
      bad_q <= '0;
    end else begin
      win_q <= win_d;
      bad_q <= bad_d;
    end
  end

endmodule

// File: rtl/eth_phy_10g_block_lock_ctrl.sv
// 10GBASE-R block-lock controller: hunts for consistent sync headers, requests bit slips
// while misaligned, and drops lock when the per-window header error count gets too high.
module eth_phy_10g_block_lock_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned LOCK_CNT  = 64,
  parameter int unsigned WINDOW    = 64,
  parameter int unsigned BAD_MAX   = 16,
  parameter int unsigned SLIP_WAIT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   hdr_in,
  input  logic                         hdr_valid,
  output logic                         slip,
  output logic                         block_lock,
  output logic                         lock_lost,
  output logic [$clog2(BAD_MAX+1)-1:0] bad_hdr_cnt,
  output logic [15:0]                  slip_cnt
);

  localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WaitW = $clog2(SLIP_WAIT + 1);

  logic [1:0]       state_q, state_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             slip_q, slip_d;
  logic             lock_q, lock_d;
  logic             lost_q, lost_d;
  logic [15:0]      slip_cnt_q, slip_cnt_d;

  logic hdr_ok;
  logic mon_sample, mon_clear, win_done, too_many_bad;

  assign hdr_ok     = is_valid_hdr(hdr_in);
  assign mon_sample = (state_q == StLocked) && hdr_valid;
  assign mon_clear  = (state_q != StLocked) || win_done || too_many_bad;

  eth_phy_10g_hdr_err_mon #(
    .WINDOW  (WINDOW),
    .BAD_MAX (BAD_MAX)
  ) u_err_mon (
    .clk          (clk),
    .reset        (reset),
    .clear        (mon_clear),
    .sample       (mon_sample),
    .bad          (!hdr_ok),
    .bad_hdr_cnt  (bad_hdr_cnt),
    .win_done     (win_done),
    .too_many_bad (too_many_bad)
  );

  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    wait_d     = wait_q;
    slip_d     = 1'b0;
    lock_d     = lock_q;
    lost_d     = 1'b0;
    slip_cnt_d = slip_cnt_q;

    case (state_q)
      StHunt: begin
        if (hdr_valid) begin
          if (hdr_ok) begin
            good_d = good_q + 1'b1;
            if (good_q == GoodW'(LOCK_CNT - 1)) begin
              state_d = StLocked;
              lock_d  = 1'b1;
            end
          end else begin
            // Pulse together with entering SLIP so it appears the cycle after the bad header.
            good_d  = '0;
            state_d = StSlip;
            slip_d  = 1'b1;
          end
        end
      end
      StSlip: begin
        // Entered from LOCKED the pulse has not fired yet; fire it before settling.
        if (slip_q) begin
          state_d = StWait;
          wait_d  = '0;
        end else begin
          slip_d = 1'b1;
        end
      end
      StWait: begin
        if (wait_q == WaitW'(SLIP_WAIT - 1)) begin
          state_d = StHunt;
          good_d  = '0;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StLocked: begin
        if (too_many_bad) begin
          state_d = StSlip;
          lock_d  = 1'b0;
          lost_d  = 1'b1;
        end
      end
      default: state_d = StHunt;
    endcase

    if (slip_d && (slip_cnt_q != 16'hFFFF)) begin
      slip_cnt_d = slip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StHunt;
      good_q     <= '0;
      wait_q     <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
      lost_q     <= 1'b0;
      slip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      wait_q     <= wait_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
      lost_q     <= lost_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  assign slip       = slip_q;
  assign block_lock = lock_q;
  assign lock_lost  = lost_q;
  assign slip_cnt   = slip_cnt_q;

endmodule

// File: tb/tb_eth_phy_10g_block_lock_ctrl.sv
// Bench for the block-lock controller: directed vectors, hand-written corner sequences and
// random headers compared against a timeline model of the lock rules.
module tb_eth_phy_10g_block_lock_ctrl;

  localparam int LOCK_CNT  = 64;
  localparam int WINDOW    = 64;
  localparam int BAD_MAX   = 16;
  localparam int SLIP_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  hdr_in = 2'b00;
  logic        hdr_valid = 1'b0;
  logic        slip, block_lock, lock_lost;
  logic [4:0]  bad_hdr_cnt;
  logic [15:0] slip_cnt;

  always #5 clk = ~clk;

  eth_phy_10g_block_lock_ctrl #(
    .LOCK_CNT  (LOCK_CNT),
    .WINDOW    (WINDOW),
    .BAD_MAX   (BAD_MAX),
    .SLIP_WAIT (SLIP_WAIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hdr_in      (hdr_in),
    .hdr_valid   (hdr_valid),
    .slip        (slip),
    .block_lock  (block_lock),
    .lock_lost   (lock_lost),
    .bad_hdr_cnt (bad_hdr_cnt),
    .slip_cnt    (slip_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Timeline model: events are scheduled at absolute cycle numbers after each decision.
  int m_cyc, m_good, m_bad, m_win, m_resume, m_slip_at, m_lost_at, m_slips;
  bit m_locked;

  function automatic void model_reset();
    m_cyc = 0; m_good = 0; m_bad = 0; m_win = 0; m_resume = 0;
    m_slip_at = -1; m_lost_at = -1; m_slips = 0; m_locked = 0;
  endfunction

  function automatic void model_step(input logic v, input logic [1:0] h);
    int c;
    bit ok;
    c  = m_cyc;
    ok = (h == 2'b01) || (h == 2'b10);
    if (m_locked) begin
      if (v) begin
        m_win++;
        if (!ok) m_bad++;
        if (m_bad == BAD_MAX) begin
          m_locked  = 0;
          m_lost_at = c + 1;
          m_slip_at = c + 2;
          m_resume  = c + 3 + SLIP_WAIT;
          m_bad = 0; m_win = 0;
        end else if (m_win == WINDOW) begin
          m_bad = 0; m_win = 0;
        end
      end
    end else if (c >= m_resume && v) begin
      if (ok) begin
        m_good++;
        if (m_good == LOCK_CNT) begin
          m_locked = 1; m_good = 0; m_bad = 0; m_win = 0;
        end
      end else begin
        m_good    = 0;
        m_slip_at = c + 1;
        m_resume  = c + 2 + SLIP_WAIT;
      end
    end
    m_cyc = c + 1;
    if (m_slip_at == m_cyc && m_slips < 65535) m_slips++;
  endfunction

  task automatic step(input logic v, input logic [1:0] h);
    hdr_valid = v;
    hdr_in    = h;
    model_step(v, h);
    @(posedge clk);
    #1;
    check("model_slip", slip, (m_slip_at == m_cyc));
    check("model_block_lock", block_lock, m_locked);
    check("model_lock_lost", lock_lost, (m_lost_at == m_cyc));
    check("model_bad_hdr_cnt", bad_hdr_cnt, m_bad);
    check("model_slip_cnt", slip_cnt, m_slips);
  endtask

  task automatic do_reset();
    hdr_valid = 1'b0;
    hdr_in    = 2'b00;
    reset     = 1'b1;
    #1;
    check("rst_slip", slip, 0);
    check("rst_block_lock", block_lock, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_bad_hdr_cnt", bad_hdr_cnt, 0);
    check("rst_slip_cnt", slip_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       v;
    logic [1:0] h;
    logic       e_slip;
    logic       e_lock;
    int         e_cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int err_pct;
    logic v;
    logic [1:0] h;

    tbl[0] = '{1'b1, 2'b11, 1'b1, 1'b0, 1};
    for (int i = 1; i <= 9; i++) tbl[i] = '{1'b1, 2'b00, 1'b0, 1'b0, 1};
    tbl[10] = '{1'b1, 2'b00, 1'b1, 1'b0, 2};

    #3;
    do_reset();

    // Lock after exactly LOCK_CNT valid headers, no slip on the way.
    for (int i = 0; i < LOCK_CNT; i++) begin
      step(1'b1, 2'b01);
      if (i == LOCK_CNT - 2) check("lock_early", block_lock, 0);
    end
    check("lock_at_64", block_lock, 1);
    check("no_slip_clean", slip_cnt, 0);

    // 15 bad headers in a window keep lock; counter clears at window end.
    for (int i = 0; i < WINDOW; i++) begin
      step(1'b1, (i < 15) ? ((i % 2) ? 2'b11 : 2'b00) : 2'b10);
      if (i == 14) check("bad15_cnt", bad_hdr_cnt, 15);
    end
    check("bad15_lock_held", block_lock, 1);
    check("bad15_window_clear", bad_hdr_cnt, 0);

    // 16th bad header drops lock; slip one cycle after lock_lost.
    for (int i = 0; i < BAD_MAX; i++) step(1'b1, 2'b11);
    check("loss_block_lock", block_lock, 0);
    check("loss_lock_lost", lock_lost, 1);
    check("loss_no_slip_yet", slip, 0);
    step(1'b0, 2'b00);
    check("loss_slip", slip, 1);
    check("loss_lost_pulse_end", lock_lost, 0);
    check("loss_slip_cnt", slip_cnt, 1);

    // Relock, then 16th bad header coincides with the 64th header of the window.
    n = 0;
    while (!block_lock && n < 200) begin
      step(1'b1, 2'b10);
      n++;
    end
    check("relock_reached", block_lock, 1);
    for (int i = 0; i < WINDOW; i++) begin
      step(1'b1, (i < 48) ? 2'b01 : 2'b00);
      if (i == WINDOW - 2) check("coincide_bad15", bad_hdr_cnt, 15);
    end
    check("coincide_block_lock", block_lock, 0);
    check("coincide_lock_lost", lock_lost, 1);

    // Reset while in WAIT.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01);
    do_reset();

    // Directed vectors: one slip, then headers ignored through the settle time.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].h);
      check("tbl_slip", slip, tbl[i].e_slip);
      check("tbl_block_lock", block_lock, tbl[i].e_lock);
      check("tbl_slip_cnt", slip_cnt, tbl[i].e_cnt);
    end

    // Reset while LOCKED, then relock needs a full fresh run.
    do_reset();
    for (int i = 0; i < LOCK_CNT; i++) step(1'b1, 2'b01);
    check("pre_reset_locked", block_lock, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b00);
    do_reset();
    for (int i = 0; i < LOCK_CNT - 1; i++) step(1'b1, 2'b10);
    check("relock_63_not_locked", block_lock, 0);
    step(1'b1, 2'b10);
    check("relock_64_locked", block_lock, 1);

    // Random headers with phases of varying error rate.
    err_pct = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 4))
          0, 1:    err_pct = 0;
          2:       err_pct = 2;
          3:       err_pct = 35;
          default: err_pct = 70;
        endcase
      end
      if (i % 1500 == 1499) do_reset();
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < err_pct) h = $urandom_range(0, 1) ? 2'b11 : 2'b00;
      else                                 h = $urandom_range(0, 1) ? 2'b10 : 2'b01;
      step(v, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
